uart_tx32: RTL and testbench
============================

# uart_tx32

Serial transmitter returning 32-bit RSA results from the `control` datapath to the host over the board UART. It is the transmit counterpart of the `uart_rxd` input path. A word is accepted on a one-cycle start strobe and sent as four back-to-back 8N1 frames, least-significant byte first, each byte LSB first. It sits between the modular-exponentiation result register and the `uart_txd` pin.

## Interface
- `CLKS_PER_BIT`, default 868, is the number of `clk` cycles per serial bit (100 MHz / 115200). The legal range is ≥ 2.
- `NUM_BYTES`, default 4, is the number of bytes per word. The data width is 8·`NUM_BYTES`.
- `clk`, input, 1 bit: system-wide clock. All state updates on the rising edge.
- `reset`, input, 1 bit: asynchronous, active-low reset. Asserting it clears all state immediately.
- `tx_start`, input, 1 bit: request strobe. Sampled only when the block is idle.
- `tx_data`, input, 32 bits: word to send. Latched in the cycle `tx_start` is accepted.
- `uart_txd`, output, 1 bit: serial line. Idles high.
- `busy`, output, 1 bit: high from the cycle after acceptance until the final stop bit completes.
- `done`, output, 1 bit: one-cycle pulse marking completion of the word.

## Operation
- Reset values:
  - `uart_txd` = 1, `busy` = 0, `done` = 0.
  - State = IDLE, bit timer = 0, bit index = 0, byte index = 0, shift register = 0.
- State machine:
  - **IDLE.** If `tx_start` = 1:
    - latch `tx_data` into the shift register;
    - clear the byte index;
    - go to START.
  - **START.** Drive `uart_txd` = 0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
  - **DATA.**
    - Drive `uart_txd` = shift register bit `8·byte_idx + bit_idx` for `CLKS_PER_BIT` cycles.
    - Increment the bit index.
    - After bit 7, go to STOP.
  - **STOP.** Drive `uart_txd` = 1 for `CLKS_PER_BIT` cycles. Then:
    - if byte index < `NUM_BYTES`−1, increment it and go to START (no idle gap);
    - otherwise go to IDLE and pulse `done`.
- Bit timer: counts 0 to `CLKS_PER_BIT`−1 and wraps to 0 at each bit boundary. It is held at 0 in IDLE.
- `tx_start` while `busy` = 1 is ignored. There is no queueing, and `tx_data` changes during transmission have no effect.
- `tx_start` in the same cycle as `done` is accepted, giving back-to-back words with no idle bit between them.
- Reset asserted mid-frame:
  - `uart_txd` returns high immediately (asynchronously);
  - the word is dropped;
  - no `done` pulse is issued;
  - after release the block is in IDLE.
- `uart_txd` is driven from a register, never combinationally, so the line is glitch-free.

## Timing
- Acceptance cycle T: `tx_start` = 1 in IDLE.
- Cycle T+1: `uart_txd` = 0 and `busy` = 1.
- Each frame lasts 10·`CLKS_PER_BIT` cycles. A word lasts 10·`NUM_BYTES`·`CLKS_PER_BIT` cycles; the default is 34 720.
- At cycle T+1+40·`CLKS_PER_BIT` (default config):
  - `busy` = 0;
  - `done` = 1 for exactly one cycle;
  - `uart_txd` = 1.
- Bit edges on `uart_txd` occur exactly every `CLKS_PER_BIT` cycles, with no drift across frames.

## Structure
- Shared package `rsa_uart_pkg` holds:
  - the state encoding (IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3);
  - the `CLKS_PER_BIT` default;
  - the frame constants (8 data bits, 1 stop bit).
  
  The future receiver reuses this package.
- One sub-module: `uart_bit_timer`.
  - Parameterised counter with `clear` and `tick` outputs.
  - `tick` is high in the last cycle of each bit period.
  - The FSM advances only on `tick`.

## Test plan
All scenarios use `CLKS_PER_BIT` = 4.

1. **Reset.** Hold `reset` = 0 for 3 cycles, then release → `uart_txd` = 1, `busy` = 0, `done` = 0 throughout, and the line stays high for 20 idle cycles.
2. **Single word.** `tx_start` pulse with `tx_data` = 32'h10100101 →
   - frames carry bytes 01, 01, 10, 10;
   - first frame line sequence is 0, 1,0,0,0,0,0,0,0, 1, each held 4 cycles;
   - `done` pulses at T+161;
   - `busy` is high for 160 cycles.
3. **Busy ignore.** Second `tx_start` with 32'hFFFFFFFF at T+50 → the output is still 32'h10100101 only, and exactly one `done` pulse occurs.
4. **Back-to-back.** Assert `tx_start` with 32'hA5A5A5A5 in the `done` cycle → the next start bit appears the following cycle, the line shows no idle-high gap, and the bytes decode as A5 ×4.
5. **Mid-frame reset.** Assert `reset` = 0 at T+70, inside frame 2 →
   - `uart_txd` = 1 in the same cycle (asynchronous);
   - `busy` = 0;
   - no `done`;
   - a fresh word 32'h00000000 afterwards transmits correctly.
6. **Timer wrap.** Check `CLKS_PER_BIT` = 2 and = 868 with 32'hDEADBEEF → the decoded bytes are EF, BE, AD, DE and every bit width is exact.

Source files
------------

// File: rtl/rsa_uart_pkg.sv
// -----------------------------------------------------------------------------
// rsa_uart_pkg
// Shared definitions for the RSA host UART path (transmitter now, receiver
// later): FSM state encoding, default bit period and 8N1 frame constants.
// -----------------------------------------------------------------------------
package rsa_uart_pkg;

  // 100 MHz system clock / 115200 baud.
  localparam int unsigned CLKS_PER_BIT_DEFAULT = 868;

  // 8N1 frame: one start bit, eight data bits, one stop bit.
  localparam int unsigned START_BITS = 1;
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned STOP_BITS  = 1;
  localparam int unsigned FRAME_BITS = START_BITS + DATA_BITS + STOP_BITS;

  // Width of an index that addresses one data bit within a byte.
  localparam int unsigned BIT_IDX_W = $clog2(DATA_BITS);

  // Serial FSM state encoding, shared with the future receiver.
  typedef logic [1:0] uart_state_t;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // Clock cycles needed to send a complete multi-byte word.
  function automatic int unsigned word_cycles(input int unsigned clks_per_bit,
                                              input int unsigned num_bytes);
    return FRAME_BITS * num_bytes * clks_per_bit;
  endfunction

endpackage : rsa_uart_pkg

// File: rtl/uart_bit_timer.sv
// -----------------------------------------------------------------------------
// uart_bit_timer
// Free-running bit-period counter for the UART. Counts 0..CLKS_PER_BIT-1 and
// wraps; held at zero while `clear` is high so the first bit of a word starts
// with a full period.
//
// Ports
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   clear  : hold the counter at zero (no tick while high)
//   tick   : high in the last cycle of each bit period
// -----------------------------------------------------------------------------
module uart_bit_timer
  import rsa_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int unsigned     CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign tick = !clear && (count_q == CNT_LAST);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    count_d = count_q + CNT_ONE;
    if (clear || tick) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule : uart_bit_timer

// File: rtl/uart_tx32.sv
// -----------------------------------------------------------------------------
// uart_tx32
// Sends a multi-byte RSA result word to the host as back-to-back 8N1 frames,
// least-significant byte first, each byte LSB first.
//
// Ports
//   clk      : system clock, all state on the rising edge
//   reset    : asynchronous active-low reset
//   tx_start : request strobe, sampled only while idle
//   tx_data  : word to send, latched when tx_start is accepted
//   uart_txd : registered serial line, idles high
//   busy     : high from the cycle after acceptance until the last stop bit ends
//   done     : one-cycle pulse when the word has been sent
// -----------------------------------------------------------------------------
module uart_tx32
  import rsa_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int unsigned NUM_BYTES    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tx_start,
  input  logic [8*NUM_BYTES-1:0] tx_data,
  output logic                   uart_txd,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned DATA_W = DATA_BITS * NUM_BYTES;
  localparam int unsigned BYTE_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int unsigned SEL_W  = BYTE_W + BIT_IDX_W;

  localparam logic [BYTE_W-1:0]    LAST_BYTE = BYTE_W'(NUM_BYTES - 1);
  localparam logic [BYTE_W-1:0]    BYTE_ONE  = BYTE_W'(1);
  localparam logic [BIT_IDX_W-1:0] LAST_BIT  = BIT_IDX_W'(DATA_BITS - 1);
  localparam logic [BIT_IDX_W-1:0] BIT_ONE   = BIT_IDX_W'(1);

  uart_state_t          state_q, state_d;
  logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [BYTE_W-1:0]    byte_idx_q, byte_idx_d;
  logic [DATA_W-1:0]    shift_q, shift_d;
  logic                 txd_q, txd_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 timer_clear;
  logic                 tick;
  logic [BIT_IDX_W-1:0] bit_idx_inc;
  logic [SEL_W-1:0]     first_sel;
  logic [SEL_W-1:0]     next_sel;

  // The timer sits at zero while idle, so the start bit gets a full period
  // beginning in the cycle after acceptance.
  assign timer_clear = (state_q == ST_IDLE);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk  (clk),
    .rst_n(reset),
    .clear(timer_clear),
    .tick (tick)
  );

  // Bit position within the latched word is {byte, bit} = 8*byte + bit,
  // because a byte holds exactly 2**BIT_IDX_W data bits.
  assign bit_idx_inc = bit_idx_q + BIT_ONE;
  assign first_sel   = {byte_idx_q, {BIT_IDX_W{1'b0}}};
  assign next_sel    = {byte_idx_q, bit_idx_inc};

  // The line value is computed for the *next* state and registered, so
  // uart_txd comes straight from a flop and changes exactly at the bit edge.
  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    txd_d      = txd_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        txd_d  = 1'b1;
        busy_d = 1'b0;
        if (tx_start) begin
          shift_d    = tx_data;
          byte_idx_d = '0;
          bit_idx_d  = '0;
          state_d    = ST_START;
          txd_d      = 1'b0;
          busy_d     = 1'b1;
        end
      end

      ST_START: begin
        if (tick) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
          txd_d     = shift_q[first_sel];
        end
      end

      ST_DATA: begin
        if (tick) begin
          bit_idx_d = bit_idx_inc;
          if (bit_idx_q == LAST_BIT) begin
            state_d = ST_STOP;
            txd_d   = 1'b1;
          end else begin
            txd_d = shift_q[next_sel];
          end
        end
      end

      ST_STOP: begin
        if (tick) begin
          if (byte_idx_q < LAST_BYTE) begin
            // Next frame starts immediately: no idle bit between bytes.
            byte_idx_d = byte_idx_q + BYTE_ONE;
            state_d    = ST_START;
            txd_d      = 1'b0;
          end else begin
            state_d = ST_IDLE;
            txd_d   = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // The reset value of txd_q is 1, so asserting reset raises the line at once
  // and abandons any word in flight without a done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      // NOTE: the shift register is a plain register, not a RAM, so it is
      // cleared with the rest of the state for a deterministic reset image.
      shift_q    <= '0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      state_q    <= state_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign uart_txd = txd_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule : uart_tx32

// File: tb/tb_uart_tx32.sv
// -----------------------------------------------------------------------------
// tb_uart_tx32
// Self-checking bench for uart_tx32. Three instances share clock and reset:
// CLKS_PER_BIT = 4 (main scenarios), 2 and 868 (timer wrap). The expected line
// waveform comes from the 8N1 framing rules applied to the word with plain
// arithmetic; the received bytes are also decoded by mid-bit sampling and
// compared against hand-written byte tables or the random word.
// -----------------------------------------------------------------------------
module tb_uart_tx32;
  import rsa_uart_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        tx_start [3];
  logic [31:0] tx_data  [3];
  logic        txd_w    [3];
  logic        busy_w   [3];
  logic        done_w   [3];

  uart_tx32 #(.CLKS_PER_BIT(4), .NUM_BYTES(4)) dut_c4 (
    .clk(clk), .reset(reset), .tx_start(tx_start[0]), .tx_data(tx_data[0]),
    .uart_txd(txd_w[0]), .busy(busy_w[0]), .done(done_w[0])
  );

  uart_tx32 #(.CLKS_PER_BIT(2), .NUM_BYTES(4)) dut_c2 (
    .clk(clk), .reset(reset), .tx_start(tx_start[1]), .tx_data(tx_data[1]),
    .uart_txd(txd_w[1]), .busy(busy_w[1]), .done(done_w[1])
  );

  uart_tx32 #(.CLKS_PER_BIT(868), .NUM_BYTES(4)) dut_c868 (
    .clk(clk), .reset(reset), .tx_start(tx_start[2]), .tx_data(tx_data[2]),
    .uart_txd(txd_w[2]), .busy(busy_w[2]), .done(done_w[2])
  );

  int n_checks = 0;
  int n_pass   = 0;

  function automatic int clks_of(input int k);
    case (k)
      0:       return 4;
      1:       return 2;
      default: return 868;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference line level at cycle idx (1 = first cycle after acceptance):
  // every bit lasts c cycles; frame slot 0 is start (0), 1..8 data LSB first,
  // 9 stop (1); frames run LSB byte first.
  function automatic logic exp_line(input logic [31:0] d, input int c, input int idx);
    int bp;
    int f;
    int b;
    bp = (idx - 1) / c;
    f  = bp % 10;
    b  = bp / 10;
    if (f == 0) return 1'b0;
    if (f == 9) return 1'b1;
    return d[8*b + f - 1];
  endfunction

  // Called right after a falling edge: asserts tx_start for this cycle (T) and
  // observes cycles T+1 .. T+1+40*c. Optionally injects a second strobe while
  // busy, and optionally asserts the next strobe in the done cycle.
  task automatic run_word(input int k, input logic [31:0] data, input logic [31:0] exp_word,
                          input int inject_at, input logic [31:0] inject_data,
                          input bit chain, input logic [31:0] chain_data, input string tag);
    int          c;
    int          last;
    int          wave_err;
    int          busy_err;
    int          done_err;
    int          bp;
    int          ph;
    logic [31:0] dec;
    logic        e_line;
    c        = clks_of(k);
    last     = int'(word_cycles(c, 4)) + 1;
    wave_err = 0;
    busy_err = 0;
    done_err = 0;
    dec      = '0;
    tx_start[k] = 1'b1;
    tx_data[k]  = data;
    for (int idx = 1; idx <= last; idx++) begin
      @(negedge clk);
      if (idx == 1) tx_start[k] = 1'b0;
      if (inject_at != 0 && idx == inject_at) begin
        tx_start[k] = 1'b1;
        tx_data[k]  = inject_data;
      end
      if (inject_at != 0 && idx == inject_at + 1) tx_start[k] = 1'b0;
      e_line = (idx == last) ? 1'b1 : exp_line(data, c, idx);
      if (txd_w[k] !== e_line) wave_err++;
      if (busy_w[k] !== (idx != last)) busy_err++;
      if (done_w[k] !== (idx == last)) done_err++;
      bp = (idx - 1) / c;
      ph = (idx - 1) % c;
      if (idx < last && (bp % 10) >= 1 && (bp % 10) <= 8 && ph == c / 2)
        dec[8*(bp/10) + (bp%10) - 1] = txd_w[k];
    end
    check({tag, "_wave_errs"}, wave_err, 0);
    check({tag, "_busy_errs"}, busy_err, 0);
    check({tag, "_done_errs"}, done_err, 0);
    check({tag, "_decoded"}, dec, exp_word);
    if (chain) begin
      tx_start[k] = 1'b1;
      tx_data[k]  = chain_data;
    end
  endtask

  task automatic idle_check(input int k, input int n, input string tag);
    int err;
    err = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (txd_w[k] !== 1'b1 || busy_w[k] !== 1'b0 || done_w[k] !== 1'b0) err++;
    end
    check({tag, "_idle_errs"}, err, 0);
  endtask

  typedef struct {
    int              k;
    logic [31:0]     data;
    int              inject_at;
    logic [31:0]     inject_data;
    logic [3:0][7:0] exp_bytes;
    string           tag;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int          err;
    logic [31:0] w;

    vecs[0] = '{0, 32'h10100101, 0,  32'h0,        {8'h10, 8'h10, 8'h01, 8'h01}, "single"};
    vecs[1] = '{0, 32'h10100101, 50, 32'hFFFFFFFF, {8'h10, 8'h10, 8'h01, 8'h01}, "busy_ignore"};
    vecs[2] = '{1, 32'hDEADBEEF, 0,  32'h0,        {8'hDE, 8'hAD, 8'hBE, 8'hEF}, "wrap_c2"};
    vecs[3] = '{0, 32'h5A3C0FF0, 0,  32'h0,        {8'h5A, 8'h3C, 8'h0F, 8'hF0}, "mixed_c4"};
    vecs[4] = '{2, 32'hDEADBEEF, 0,  32'h0,        {8'hDE, 8'hAD, 8'hBE, 8'hEF}, "wrap_c868"};

    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tx_start[k] = 1'b0;
      tx_data[k]  = '0;
    end

    // Reset held for three cycles, then twenty idle cycles on every instance.
    err = 0;
    repeat (3) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++)
        if (txd_w[k] !== 1'b1 || busy_w[k] !== 1'b0 || done_w[k] !== 1'b0) err++;
    end
    check("reset_hold_errs", err, 0);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) idle_check(k, 20, "reset_release");

    // Table-driven words.
    for (int v = 0; v < 5; v++) begin
      @(negedge clk);
      run_word(vecs[v].k, vecs[v].data, vecs[v].exp_bytes, vecs[v].inject_at,
               vecs[v].inject_data, 1'b0, 32'h0, vecs[v].tag);
      idle_check(vecs[v].k, 60, {vecs[v].tag, "_after"});
    end

    // Back-to-back: next strobe in the done cycle, start bit follows directly.
    @(negedge clk);
    run_word(0, 32'h10100101, 32'h10100101, 0, 32'h0, 1'b1, 32'hA5A5A5A5, "b2b_first");
    run_word(0, 32'hA5A5A5A5, {8'hA5, 8'hA5, 8'hA5, 8'hA5}, 0, 32'h0, 1'b0, 32'h0, "b2b_second");
    idle_check(0, 20, "b2b_after");

    // Mid-frame reset at T+70 (inside frame 2): line rises without a clock edge.
    @(negedge clk);
    tx_start[0] = 1'b1;
    tx_data[0]  = 32'h10100101;
    for (int idx = 1; idx <= 70; idx++) begin
      @(negedge clk);
      if (idx == 1) tx_start[0] = 1'b0;
    end
    check("midrst_line_before", txd_w[0], exp_line(32'h10100101, 4, 70));
    check("midrst_busy_before", busy_w[0], 1'b1);
    reset = 1'b0;
    #1;
    check("midrst_txd_async", txd_w[0], 1'b1);
    check("midrst_busy_async", busy_w[0], 1'b0);
    check("midrst_done_async", done_w[0], 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    idle_check(0, 200, "midrst_no_done");
    @(negedge clk);
    run_word(0, 32'h00000000, {8'h00, 8'h00, 8'h00, 8'h00}, 0, 32'h0, 1'b0, 32'h0, "after_midrst");
    idle_check(0, 10, "after_midrst_tail");

    // Random words against the framing model.
    for (int r = 0; r < 8; r++) begin
      w = $urandom;
      @(negedge clk);
      run_word((r < 6) ? 0 : 1, w, w, 0, 32'h0, 1'b0, 32'h0, $sformatf("rand%0d", r));
      idle_check((r < 6) ? 0 : 1, 5, $sformatf("rand%0d_after", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_uart_tx32
